// File: rtl/clk_phase_alloc.sv
// clk_phase_alloc: derives NUM_CH programmable-window clocks from one master clock, with hold handshake.
// Optional 32-bit completed-period counter enabled by defining CLK_ALLOC_PERIOD_CNT_EN.
module clk_phase_alloc #(
    parameter int NUM_CH = 4,
    parameter int DIV    = 4,
    parameter int CNT_W  = 4,
    parameter int CH_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_rise,
    input  logic [CNT_W-1:0]  cfg_fall,
    output logic              cfg_err,
    input  logic              hold_req,
    output logic              hold_ack,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] ph_rise,
    output logic              period_start,
    output logic [31:0]       period_cnt
);
    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF   = CNT_W'(DIV / 2);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]  r_act_rise [NUM_CH];
    logic [CNT_W-1:0]  r_act_fall [NUM_CH];
    logic [CNT_W-1:0]  r_pnd_rise [NUM_CH];
    logic [CNT_W-1:0]  r_pnd_fall [NUM_CH];
    logic [CNT_W-1:0]  w_rise_nxt [NUM_CH];
    logic [CNT_W-1:0]  w_fall_nxt [NUM_CH];
    logic [NUM_CH-1:0] r_pnd_vld;
    logic [NUM_CH-1:0] w_clk_nxt;
    logic              w_end, w_apply, w_cfg_ok;

    function automatic logic win(input logic [CNT_W-1:0] c, r, f);
        return (r < f) ? (c >= r && c < f) : (r > f) ? (c >= r || c < f) : 1'b0;
    endfunction

    assign hold_ack = (r_state == HOLD);
    assign w_cfg_ok = cfg_wr
                    && ({{(32-CH_W){1'b0}}, cfg_ch} < 32'(NUM_CH))
                    && ({{(32-CNT_W){1'b0}}, cfg_rise} < 32'(DIV))
                    && ({{(32-CNT_W){1'b0}}, cfg_fall} < 32'(DIV));

    always_comb begin
        w_end       = (r_state == RUN) && (r_cnt == LAST);
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        if (r_state == RUN) begin
            w_cnt_nxt = w_end ? '0 : r_cnt + 1'b1;
            if (w_end && hold_req)
                w_state_nxt = HOLD;
        end else if (!hold_req) begin
            w_state_nxt = RUN;
        end
        // period wrap, hold entry and hold exit all promote pending windows
        w_apply = w_end || (r_state == HOLD && !hold_req);
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_rise_nxt[i] = (w_apply && r_pnd_vld[i]) ? r_pnd_rise[i] : r_act_rise[i];
            w_fall_nxt[i] = (w_apply && r_pnd_vld[i]) ? r_pnd_fall[i] : r_act_fall[i];
            w_clk_nxt[i]  = (w_state_nxt == RUN) && win(w_cnt_nxt, w_rise_nxt[i], w_fall_nxt[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_pnd_vld    <= '0;
            clk_out      <= '0;
            ph_rise      <= '0;
            period_start <= 1'b0;
            cfg_err      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_act_rise[i] <= '0;
                r_act_fall[i] <= HALF;
                r_pnd_rise[i] <= '0;
                r_pnd_fall[i] <= HALF;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            clk_out      <= w_clk_nxt;
            ph_rise      <= w_clk_nxt & ~clk_out;
            period_start <= (w_state_nxt == RUN) && (w_cnt_nxt == '0);
            cfg_err      <= cfg_wr && !w_cfg_ok;
            for (int i = 0; i < NUM_CH; i++) begin
                r_act_rise[i] <= w_rise_nxt[i];
                r_act_fall[i] <= w_fall_nxt[i];
                if (w_apply)
                    r_pnd_vld[i] <= 1'b0;
                // a write in the boundary cycle lands after the copy, so it waits for the next boundary
                if (w_cfg_ok && cfg_ch == CH_W'(i)) begin
                    r_pnd_vld[i]  <= 1'b1;
                    r_pnd_rise[i] <= cfg_rise;
                    r_pnd_fall[i] <= cfg_fall;
                end
            end
        end
    end

`ifdef CLK_ALLOC_PERIOD_CNT_EN
    logic [31:0] r_period_cnt;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_period_cnt <= '0;
        else if (w_end)
            r_period_cnt <= r_period_cnt + 32'd1;
    end
    assign period_cnt = r_period_cnt;
`else
    assign period_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_clk_phase_alloc.sv
// tb_clk_phase_alloc: directed checks of windows, config rejection, boundary timing, hold and async reset.
module tb_clk_phase_alloc;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [3:0]  cfg_rise = '0;
    logic [3:0]  cfg_fall = '0;
    logic        hold_req = 1'b0;
    logic        cfg_err, hold_ack, period_start;
    logic [3:0]  clk_out, ph_rise;
    logic [31:0] period_cnt;
    int          total = 0;
    int          bad = 0;

    clk_phase_alloc dut (
        .clock(clock), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_rise(cfg_rise), .cfg_fall(cfg_fall), .cfg_err(cfg_err),
        .hold_req(hold_req), .hold_ack(hold_ack), .clk_out(clk_out),
        .ph_rise(ph_rise), .period_start(period_start), .period_cnt(period_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] e_clk, input logic e_ps);
        chk({tag, ".clk"}, {28'd0, clk_out}, {28'd0, e_clk});
        chk({tag, ".ps"}, {31'd0, period_start}, {31'd0, e_ps});
        chk({tag, ".ack"}, {31'd0, hold_ack}, 32'd0);
        @(negedge clock);
    endtask

    task automatic cw(input string tag, input logic [3:0] e_clk, input logic e_ps,
                      input logic [1:0] ch, input logic [3:0] r, input logic [3:0] f);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_rise = r; cfg_fall = f;
        cyc(tag, e_clk, e_ps);
        cfg_wr = 1'b0;
    endtask

    task automatic per(input string tag, input logic [3:0] c0, c1, c2, c3);
        cyc({tag, "c0"}, c0, 1'b1);
        cyc({tag, "c1"}, c1, 1'b0);
        cyc({tag, "c2"}, c2, 1'b0);
        cyc({tag, "c3"}, c3, 1'b0);
    endtask

    task automatic wfs(input string tag);
        int n = 0;
        while (!period_start && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, ".sync"}, {31'd0, period_start}, 32'd1);
    endtask

    initial begin
        @(negedge clock);
        chk("rst.clk", {28'd0, clk_out}, 32'd0);
        chk("rst.ph", {28'd0, ph_rise}, 32'd0);
        chk("rst.ps", {31'd0, period_start}, 32'd0);
        chk("rst.ack", {31'd0, hold_ack}, 32'd0);
        chk("rst.err", {31'd0, cfg_err}, 32'd0);
        chk("rst.pcnt", period_cnt, 32'd0);
        reset = 1'b1;
        wfs("p0");
        chk("p0.ph", {28'd0, ph_rise}, 32'hF);
        per("p0", 4'hF, 4'hF, 4'h0, 4'h0);
        // ch1 wrap window written mid-period
        cyc("p1c0", 4'hF, 1'b1);
        cw("p1c1", 4'hF, 1'b0, 2'd1, 4'd3, 4'd1);
        chk("p1.err", {31'd0, cfg_err}, 32'd0);
        cyc("p1c2", 4'h0, 1'b0);
        cyc("p1c3", 4'h0, 1'b0);
        // rejected write, then ch3 disable
        cyc("p2c0", 4'hF, 1'b1);
        cw("p2c1", 4'hD, 1'b0, 2'd2, 4'd4, 4'd0);
        chk("p2.err1", {31'd0, cfg_err}, 32'd1);
        cw("p2c2", 4'h0, 1'b0, 2'd3, 4'd2, 4'd2);
        chk("p2.err0", {31'd0, cfg_err}, 32'd0);
        chk("p2.ph3", {28'd0, ph_rise}, 32'h2);
        cyc("p2c3", 4'h2, 1'b0);
        // two writes to ch0 before the boundary: the second one wins
        chk("p3.ph0", {28'd0, ph_rise}, 32'h5);
        cyc("p3c0", 4'h7, 1'b1);
        cw("p3c1", 4'h5, 1'b0, 2'd0, 4'd3, 4'd0);
        cw("p3c2", 4'h0, 1'b0, 2'd0, 4'd1, 4'd3);
        cyc("p3c3", 4'h2, 1'b0);
        // write in the boundary cycle waits a full period
        cyc("p4c0", 4'h6, 1'b1);
        cyc("p4c1", 4'h5, 1'b0);
        cyc("p4c2", 4'h1, 1'b0);
        cw("p4c3", 4'h2, 1'b0, 2'd0, 4'd0, 4'd2);
        per("p5", 4'h6, 4'h5, 4'h1, 4'h2);
        per("p6", 4'h7, 4'h5, 4'h0, 4'h2);
        // hold requested mid-period
        cyc("p7c0", 4'h7, 1'b1);
        hold_req = 1'b1;
        cyc("p7c1", 4'h5, 1'b0);
        cyc("p7c2", 4'h0, 1'b0);
        cyc("p7c3", 4'h2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("hold.ack", {31'd0, hold_ack}, 32'd1);
            chk("hold.clk", {28'd0, clk_out}, 32'd0);
            chk("hold.ph", {28'd0, ph_rise}, 32'd0);
            chk("hold.ps", {31'd0, period_start}, 32'd0);
            if (k == 0) begin
                cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_rise = 4'd1; cfg_fall = 4'd2;
            end
            if (k == 4)
                hold_req = 1'b0;
            @(negedge clock);
            cfg_wr = 1'b0;
        end
        chk("exit.ph", {28'd0, ph_rise}, 32'h3);
        cyc("p8c0", 4'h3, 1'b1);
        hold_req = 1'b1;
        cyc("p8c1", 4'h5, 1'b0);
        hold_req = 1'b0;
        cyc("p8c2", 4'h0, 1'b0);
        cyc("p8c3", 4'h2, 1'b0);
        per("p9", 4'h3, 4'h5, 4'h0, 4'h2);
        // async reset discards a pending ch0 config
        cw("p10c0", 4'h3, 1'b1, 2'd0, 4'd3, 4'd0);
        chk("p10.clk1", {28'd0, clk_out}, 32'h5);
        reset = 1'b0;
        #1;
        chk("arst.clk", {28'd0, clk_out}, 32'd0);
        chk("arst.ph", {28'd0, ph_rise}, 32'd0);
        chk("arst.ps", {31'd0, period_start}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        wfs("p11");
        per("p11", 4'hF, 4'hF, 4'h0, 4'h0);
        per("p12", 4'hF, 4'hF, 4'h0, 4'h0);
`ifndef CLK_ALLOC_PERIOD_CNT_EN
        chk("pcnt", period_cnt, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
